e_mdu_ctrl: RTL

- Multiply/divide sequencer for the E stage; sits beside the E-stage ALU and owns the HI/LO registers.
- Accepts one MD instruction per `start`, computes the result, and runs a fixed-latency busy window.
- Commits HI/LO only at the end of that window.
- The hazard unit stalls D on `busy`, or on `start` with a following MD instruction, so that HI/LO timing matches the multicycle model.

---
 rtl/e_mdu_ctrl_pkg.sv | 43 ++++
 rtl/e_mdu_ctrl_timer.sv | 40 ++++
 rtl/e_mdu_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/e_mdu_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, FSM states
// and the combinational divide helper.
package e_mdu_ctrl_pkg;

   localparam logic [3:0] MDU_NONE  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;
   localparam logic [3:0] MDU_MADD  = 4'd9;
   localparam logic [3:0] MDU_MADDU = 4'd10;
   localparam logic [3:0] MDU_MSUB  = 4'd11;
   localparam logic [3:0] MDU_MSUBU = 4'd12;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdu_state_e;

   // Returns {remainder, quotient}. Signed mode divides magnitudes and fixes the
   // signs afterwards, so 0x80000000 / -1 lands on 0x80000000 with no overflow case.
   function automatic logic [63:0] divmod(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
      logic [31:0] ma, mb, uq, ur, q, r;
      ma = (sgn && a[31]) ? (~a + 32'd1) : a;
      mb = (sgn && b[31]) ? (~b + 32'd1) : b;
      if (mb == 32'd0) begin
         uq = 32'd0;
         ur = 32'd0;
      end else begin
         uq = ma / mb;
         ur = ma % mb;
      end
      q = (sgn && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
      r = (sgn && a[31]) ? (~ur + 32'd1) : ur;
      return {r, q};
   endfunction

endpackage

// File: rtl/e_mdu_ctrl_timer.sv
// Busy-window timer: 4-bit load/decrement counter, registered busy and a
// done pulse during the last busy cycle.
module e_mdu_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       busy,
   output logic       done
);

   logic [3:0] count_q, count_d;
   logic       busy_q, busy_d;

   always_comb begin
      count_d = count_q;
      busy_d  = busy_q;
      if (load) begin
         count_d = load_val;
         busy_d  = (load_val != 4'd0);
      end else if (count_q != 4'd0) begin
         count_d = count_q - 4'd1;
         busy_d  = (count_q > 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 4'd0;
         busy_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         busy_q  <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = (count_q == 4'd1);

endmodule

// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO. Optional MADD/MSUB family is
// enabled by defining MDU_MADD_EN.
module e_mdu_ctrl
   import e_mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_rd
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   // Reset asserts asynchronously, releases two clocks later in this domain.
   logic [1:0] rst_sync_q, rst_sync_d;
   logic       rst_n;

   always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= rst_sync_d;
   end

   assign rst_n = rst_sync_q[1];

   mdu_state_e  state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] pend_q, pend_d;
   logic        wr_q, wr_d;
   logic        t_load, t_busy, t_done;
   logic [3:0]  t_val;

   logic        is_mul, is_div, op_sgn;
   logic [63:0] a_ext, b_ext, prod, mul_pend;

`ifdef MDU_MADD_EN
   logic        is_madd, madd_sub;
`endif

   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      op_sgn = 1'b0;
`ifdef MDU_MADD_EN
      is_madd  = 1'b0;
      madd_sub = 1'b0;
`endif
      case (mdu_op)
         MDU_MULT:  begin is_mul = 1'b1; op_sgn = 1'b1; end
         MDU_MULTU: is_mul = 1'b1;
         MDU_DIV:   begin is_div = 1'b1; op_sgn = 1'b1; end
         MDU_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
         MDU_MADD:  begin is_mul = 1'b1; is_madd = 1'b1; op_sgn = 1'b1; end
         MDU_MADDU: begin is_mul = 1'b1; is_madd = 1'b1; end
         MDU_MSUB:  begin is_mul = 1'b1; is_madd = 1'b1; op_sgn = 1'b1; madd_sub = 1'b1; end
         MDU_MSUBU: begin is_mul = 1'b1; is_madd = 1'b1; madd_sub = 1'b1; end
`endif
         default: ;
      endcase
   end

   assign a_ext = op_sgn ? {{32{A[31]}}, A} : {32'd0, A};
   assign b_ext = op_sgn ? {{32{B[31]}}, B} : {32'd0, B};
   assign prod  = a_ext * b_ext;

`ifdef MDU_MADD_EN
   // Accumulate against HI/LO as they stand at start; wraps mod 2^64.
   assign mul_pend = !is_madd ? prod
                   : (madd_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod));
`else
   assign mul_pend = prod;
`endif

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      pend_d  = pend_q;
      wr_d    = wr_q;
      t_load  = 1'b0;
      t_val   = MULT_N;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (is_mul) begin
                  pend_d  = mul_pend;
                  wr_d    = 1'b1;
                  t_load  = 1'b1;
                  t_val   = MULT_N;
                  state_d = BUSY;
               end else if (is_div) begin
                  // Divide-by-zero still runs the full window but never commits.
                  pend_d  = divmod(A, B, op_sgn);
                  wr_d    = (B != 32'd0);
                  t_load  = 1'b1;
                  t_val   = DIV_N;
                  state_d = BUSY;
               end else if (mdu_op == MDU_MTHI) begin
                  hi_d = A;
               end else if (mdu_op == MDU_MTLO) begin
                  lo_d = A;
               end
            end
         end
         BUSY: begin
            if (t_done) begin
               if (wr_q) {hi_d, lo_d} = pend_q;
               wr_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         pend_q  <= 64'd0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         pend_q  <= pend_d;
         wr_q    <= wr_d;
      end
   end

   e_mdu_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .load_val (t_val),
      .busy     (t_busy),
      .done     (t_done)
   );

   always_comb begin
      mdu_rd = 32'd0;
      if (mdu_op == MDU_MFHI)      mdu_rd = hi_q;
      else if (mdu_op == MDU_MFLO) mdu_rd = lo_q;
   end

   assign busy = t_busy;
   assign hi   = hi_q;
   assign lo   = lo_q;

   // The hazard unit must hold MD instructions in D while an operation is in flight.
   a_no_start_busy: assert property (@(posedge clk) disable iff (!rst_n) !(start && t_busy))
      else $error("e_mdu_ctrl: start while busy ignored");

endmodule
